// File: rtl/seq_shift_rotate_unit_if.sv
// Command/result bundle for seq_shift_rotate_unit: start/ready/done handshake plus operand and result.
interface seq_shift_rotate_unit_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned AW = $clog2(N);

  logic          start;
  logic [N-1:0]  x;
  logic [1:0]    select;
  logic [AW-1:0] amount;
  logic          ready;
  logic          busy;
  logic          done;
  logic [N-1:0]  y;

  modport master (
    output start, x, select, amount,
    input  ready, busy, done, y
  );

  modport slave (
    input  start, x, select, amount,
    output ready, busy, done, y
  );
endinterface

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate engine, one bit position per clock.
// Define SHIFT_ROTATE_SRA_EN to make select=01 an arithmetic right shift.
module seq_shift_rotate_unit #(
  parameter int unsigned N = 8
) (
  input logic                   clk,
  input logic                   reset,
  seq_shift_rotate_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  wreg;
  logic [N-1:0]  wreg_step;
  logic [1:0]    op;
  logic [AW-1:0] cnt;
  logic [N-1:0]  y_q;

  // Single-position move of w according to the select encoding.
  function automatic logic [N-1:0] step(input logic [N-1:0] w, input logic [1:0] sel);
    logic [N-1:0] r;
    r = w;
    case (sel)
      2'b00: r = {w[N-2:0], 1'b0};
`ifdef SHIFT_ROTATE_SRA_EN
      2'b01: r = {w[N-1], w[N-1:1]};
`else
      2'b01: r = {1'b0, w[N-1:1]};
`endif
      2'b10: r = {w[N-2:0], w[N-1]};
      2'b11: r = {w[0], w[N-1:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign wreg_step = step(wreg, op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == AW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the one-hot state flops.
  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE:    bus.ready = 1'b1;
      SHIFT:   bus.busy  = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  // Operand capture, stepping and result update; start is ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      wreg <= '0;
      op   <= 2'b00;
      cnt  <= '0;
      y_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            wreg <= bus.x;
            op   <= bus.select;
            cnt  <= bus.amount;
            if (bus.amount == '0) begin
              y_q <= bus.x;
            end
          end
        end
        SHIFT: begin
          wreg <= wreg_step;
          cnt  <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            y_q <= wreg_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Scoreboard bench for seq_shift_rotate_unit: directed cases then randomized traffic with resets.
module tb_seq_shift_rotate_unit;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = $clog2(N);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_shift_rotate_unit_if #(.N(N)) bus ();

  seq_shift_rotate_unit #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] y;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           acc_cyc[$];
  int           checks  = 0;
  int           errors  = 0;
  int           cyc     = 0;
  int           acc_cnt = 0;
  logic         rst_edge = 1'b1;
  logic [N-1:0] prev_y   = '0;

  // Reference result from whole-word arithmetic on the operand.
  function automatic logic [N-1:0] model(input logic [N-1:0] v, input logic [1:0] sel, input int amt);
    longint unsigned u;
    longint unsigned m;
    logic signed [N-1:0] s;
    u = 64'(v);
    m = (64'd1 << N) - 64'd1;
    s = v;
    case (sel)
      2'd0: return N'((u << amt) & m);
`ifdef SHIFT_ROTATE_SRA_EN
      2'd1: return N'(s >>> amt);
`else
      2'd1: return N'(u >> amt);
`endif
      2'd2: return N'(((u << amt) | (u >> (N - amt))) & m);
      default: return N'(((u >> amt) | (u << (N - amt))) & m);
    endcase
  endfunction

  // Cycle count = number of rising edges so far; reset kills every in-flight operation.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
    if (reset) q.delete();
  end

  // Acceptance sampler: a command is taken on the coming edge when start && ready && !reset.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.start && bus.ready) begin
      e.y   = model(bus.x, bus.select, int'(bus.amount));
      e.cyc = cyc + 1 + int'(bus.amount);
      q.push_back(e);
      acc_cyc.push_back(cyc + 1);
      acc_cnt++;
    end
  end

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (bus.ready !== !bus.busy) begin
        errors++;
        $display("FAIL handshake cyc=%0d ready=%b busy=%b (expected ready == !busy)", cyc, bus.ready, bus.busy);
      end
      if (bus.done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d y=%h (no command outstanding)", cyc, bus.y);
        end else begin
          e = q.pop_front();
          if (bus.y !== e.y || cyc != e.cyc) begin
            errors++;
            $display("FAIL result cyc=%0d y=%h expected cyc=%0d y=%h", cyc, bus.y, e.cyc, e.y);
          end
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].cyc) begin
          checks++;
          errors++;
          $display("FAIL done_missing cyc=%0d expected done at cyc=%0d y=%h", cyc, q[0].cyc, q[0].y);
          void'(q.pop_front());
        end
        if (!rst_edge) begin
          checks++;
          if (bus.y !== prev_y) begin
            errors++;
            $display("FAIL y_hold cyc=%0d y=%h expected held %h", cyc, bus.y, prev_y);
          end
        end
      end
    end
    prev_y = bus.y;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.ready) return;
    end
    chk("idle_timeout", longint'(q.size()), 0);
  endtask

  task automatic issue(input logic [N-1:0] xi, input logic [1:0] si, input int ai);
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.x      = xi;
    bus.select = si;
    bus.amount = AW'(ai);
    wait_ready();
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.x      = N'($urandom);
    bus.select = 2'($urandom);
    bus.amount = AW'($urandom);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bidx;
    bus.start  = 1'b0;
    bus.x      = '0;
    bus.select = 2'b00;
    bus.amount = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", longint'(bus.ready), 1);
    chk("reset_busy",  longint'(bus.busy),  0);
    chk("reset_done",  longint'(bus.done),  0);
    chk("reset_y",     longint'(bus.y),     0);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(8'h96, 2'b10, 3);
    issue(8'h96, 2'b00, 2);
    issue(8'h96, 2'b01, 3);
    issue(8'h81, 2'b11, 1);
    issue(8'h5A, 2'($urandom), 0);
    issue(8'hC3, 2'b11, 7);
    issue(8'h80, 2'b01, 7);

    // start held high for a long operation; operand changes mid-flight
    base = acc_cnt;
    bidx = acc_cyc.size();
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.x      = 8'h01;
    bus.select = 2'b10;
    bus.amount = AW'(7);
    for (int i = 0; i < 50 && acc_cnt < base + 1; i++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1 bus.x = 8'hFF;
    for (int i = 0; i < 50 && acc_cnt < base + 2; i++) @(negedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (acc_cyc.size() >= bidx + 2)
      chk("b2b_spacing", longint'(acc_cyc[bidx+1] - acc_cyc[bidx]), 9);
    else
      chk("b2b_accepts", longint'(acc_cyc.size() - bidx), 2);
    wait_idle();

    // reset in the middle of SHIFT: no done, outputs back to reset values
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.x      = 8'hF0;
    bus.select = 2'b00;
    bus.amount = AW'(5);
    wait_ready();
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_y",     longint'(bus.y),     0);
    chk("abort_ready", longint'(bus.ready), 1);
    chk("abort_busy",  longint'(bus.busy),  0);
    chk("abort_done",  longint'(bus.done),  0);
    repeat (8) @(negedge clk);
    issue(8'h3C, 2'b10, 4);

    // randomized traffic, including starts while busy and occasional resets
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      bus.start  = ($urandom % 3) == 0;
      bus.x      = N'($urandom);
      bus.select = 2'($urandom);
      bus.amount = AW'($urandom % N);
      reset      = ($urandom % 200) == 0;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
